// File: rtl/cond_logic_pkg.sv
// -----------------------------------------------------------------------------
// cond_logic_pkg
// Shared definitions for the condition unit: 4-bit condition-field encodings
// and bit positions of the packed {N,Z,C,V} flags word. The decoder and the
// bench import the same package so encodings can never drift apart.
// -----------------------------------------------------------------------------
package cond_logic_pkg;

    localparam int COND_WIDTH = 4;
    localparam int FLAGS_WIDTH = 4;

    // Condition field encodings (Instr[31:28])
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;  // reserved, never executes

    // Bit positions inside the packed flags word {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_logic_if.sv
// -----------------------------------------------------------------------------
// cond_logic_if
// Bundles the decoder/ALU-facing inputs and the gated write strobes of the
// condition unit.
//   master : decoder/ALU side -- drives Cond, ALUFlags, FlagW, PCS, RegW, MemW,
//            NoWrite; observes PCSrc, RegWrite, MemWrite, Flags, CondEx.
//   slave  : cond_logic side -- the reverse.
// Handshake: none. Every signal is a plain per-cycle level; the strobes are
// valid in the same cycle as the instruction fields that produce them.
// -----------------------------------------------------------------------------
interface cond_logic_if;
    import cond_logic_pkg::*;

    logic [COND_WIDTH-1:0]  Cond;
    logic [FLAGS_WIDTH-1:0] ALUFlags;
    logic [1:0]             FlagW;
    logic                   PCS;
    logic                   RegW;
    logic                   MemW;
    logic                   NoWrite;
    logic                   PCSrc;
    logic                   RegWrite;
    logic                   MemWrite;
    logic [FLAGS_WIDTH-1:0] Flags;
    logic                   CondEx;

    modport master (
        output Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
        input  PCSrc, RegWrite, MemWrite, Flags, CondEx
    );

    modport slave (
        input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
        output PCSrc, RegWrite, MemWrite, Flags, CondEx
    );

endinterface

// File: rtl/cond_logic_check.sv
// -----------------------------------------------------------------------------
// cond_check
// Purely combinational evaluation of a 4-bit condition field against a packed
// {N,Z,C,V} flags word.
//   i_cond    in  4  condition field
//   i_flags   in  4  flags {N,Z,C,V}
//   o_cond_ex out 1  1 when the condition holds
// -----------------------------------------------------------------------------
module cond_check
    import cond_logic_pkg::*;
(
    input  logic [COND_WIDTH-1:0]  i_cond,
    input  logic [FLAGS_WIDTH-1:0] i_flags,
    output logic                   o_cond_ex
);

    logic w_n, w_z, w_c, w_v;
    logic w_ge;

    assign w_n  = i_flags[FLAG_N];
    assign w_z  = i_flags[FLAG_Z];
    assign w_c  = i_flags[FLAG_C];
    assign w_v  = i_flags[FLAG_V];
    // Signed greater-or-equal: sign of the result agrees with overflow.
    assign w_ge = ~(w_n ^ w_v);

    always_comb begin
        o_cond_ex = 1'b0;
        case (i_cond)
            COND_EQ: o_cond_ex = w_z;
            COND_NE: o_cond_ex = ~w_z;
            COND_CS: o_cond_ex = w_c;
            COND_CC: o_cond_ex = ~w_c;
            COND_MI: o_cond_ex = w_n;
            COND_PL: o_cond_ex = ~w_n;
            COND_VS: o_cond_ex = w_v;
            COND_VC: o_cond_ex = ~w_v;
            COND_HI: o_cond_ex = w_c & ~w_z;
            COND_LS: o_cond_ex = ~w_c | w_z;
            COND_GE: o_cond_ex = w_ge;
            COND_LT: o_cond_ex = ~w_ge;
            COND_GT: o_cond_ex = ~w_z & w_ge;
            COND_LE: o_cond_ex = w_z | ~w_ge;
            COND_AL: o_cond_ex = 1'b1;
            default: o_cond_ex = 1'b0;  // COND_NV: reserved, never executes
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// -----------------------------------------------------------------------------
// cond_logic
// Condition unit downstream of the ALU. Holds the architectural {N,Z,C,V}
// flags register, evaluates the instruction's condition field against the
// registered flags and gates the decoder's PC/register/memory write strobes.
//   clk    in  1  clock, rising edge
//   reset  in  1  synchronous active-high reset
//   bus    cond_logic_if.slave
//          in : Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite
//          out: PCSrc, RegWrite, MemWrite, Flags, CondEx
// -----------------------------------------------------------------------------
module cond_logic
    import cond_logic_pkg::*;
#(
    parameter logic [3:0] FLAGS_RST = 4'b0000,
    parameter int          COND_W    = 4       // only 4 is supported
)(
    input  logic         clk,
    input  logic         reset,
    cond_logic_if.slave  bus
);

    logic [1:0]        r_nz;       // {N,Z}
    logic [1:0]        r_cv;       // {C,V}
    logic [3:0]        w_flags;
    logic [COND_W-1:0] w_cond;
    logic              w_pass;     // unmasked condition result
    logic              w_cond_ex;  // masked during reset

    assign w_flags = {r_nz, r_cv};
    assign w_cond  = bus.Cond;

    cond_check u_cond_check (
        .i_cond    (w_cond),
        .i_flags   (w_flags),
        .o_cond_ex (w_pass)
    );

    // Mask while reset is high so no write strobe escapes mid-reset.
    assign w_cond_ex = w_pass & ~reset;

    // Condition is evaluated against pre-update flags; an instruction never
    // sees its own flag result. Each half updates independently.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_nz <= FLAGS_RST[3:2];
            r_cv <= FLAGS_RST[1:0];
        end else begin
            if (bus.FlagW[1] && w_pass) r_nz <= bus.ALUFlags[3:2];
            if (bus.FlagW[0] && w_pass) r_cv <= bus.ALUFlags[1:0];
        end
    end

    assign bus.CondEx   = w_cond_ex;
    assign bus.PCSrc    = bus.PCS & w_cond_ex;
    assign bus.RegWrite = bus.RegW & w_cond_ex & ~bus.NoWrite;
    assign bus.MemWrite = bus.MemW & w_cond_ex;
    assign bus.Flags    = w_flags;

endmodule

// File: tb/tb_cond_logic.sv
// -----------------------------------------------------------------------------
// tb_cond_logic
// Self-checking bench for cond_logic. Scenario tasks drive the interface and
// compare against a behavioural model of the condition table and flag
// register kept in the bench.
// -----------------------------------------------------------------------------
module tb_cond_logic;
    import cond_logic_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [3:0] model_flags;

    cond_logic_if bus ();

    cond_logic #(.FLAGS_RST(4'b0000), .COND_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural condition table, written from the mnemonic meanings.
    function automatic logic ref_cond(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        logic signed_ge, unsigned_hi;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        signed_ge   = (n == v);
        unsigned_hi = (c == 1'b1) && (z == 1'b0);
        case (cond)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return c;
            4'd3:    return !c;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return unsigned_hi;
            4'd9:    return !unsigned_hi;
            4'd10:   return signed_ge;
            4'd11:   return !signed_ge;
            4'd12:   return signed_ge && !z;
            4'd13:   return !(signed_ge && !z);
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Model of the registered flags across one rising edge.
    function automatic logic [3:0] next_flags(input logic [3:0] f, input logic rst,
                                              input logic [3:0] cond, input logic [1:0] fw,
                                              input logic [3:0] alu);
        logic [3:0] nf;
        nf = f;
        if (rst) return 4'b0000;
        if (ref_cond(cond, f)) begin
            if (fw[1]) begin nf[3] = alu[3]; nf[2] = alu[2]; end
            if (fw[0]) begin nf[1] = alu[1]; nf[0] = alu[0]; end
        end
        return nf;
    endfunction

    task automatic clear_inputs();
        bus.Cond = COND_AL; bus.ALUFlags = 4'b0000; bus.FlagW = 2'b00;
        bus.PCS = 1'b0; bus.RegW = 1'b0; bus.MemW = 1'b0; bus.NoWrite = 1'b0;
    endtask

    // Advance one clock, applying the model to the current inputs.
    task automatic tick();
        model_flags = next_flags(model_flags, reset, bus.Cond, bus.FlagW, bus.ALUFlags);
        @(posedge clk);
        #1;
    endtask

    task automatic load_flags(input logic [3:0] f);
        reset = 1'b0;
        clear_inputs();
        bus.FlagW = 2'b11; bus.ALUFlags = f;
        #1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        bus.FlagW = 2'b11; bus.ALUFlags = 4'b1111; bus.RegW = 1'b1;
        bus.PCS = 1'b1; bus.MemW = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (bus.RegWrite !== 1'b0 || bus.CondEx !== 1'b0 || bus.PCSrc !== 1'b0 || bus.MemWrite !== 1'b0) begin
                errors++;
                $display("FAIL reset_mask: RegWrite=%b CondEx=%b PCSrc=%b MemWrite=%b expected all 0",
                         bus.RegWrite, bus.CondEx, bus.PCSrc, bus.MemWrite);
            end
            tick();
        end
        checks++;
        if (bus.Flags !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", bus.Flags);
        end
    endtask

    task automatic test_cmp_eq();
        reset = 1'b0;
        clear_inputs();
        bus.Cond = COND_AL; bus.FlagW = 2'b11; bus.NoWrite = 1'b1; bus.RegW = 1'b1;
        bus.ALUFlags = 4'b0100;
        #1;
        checks++;
        if (bus.RegWrite !== 1'b0 || bus.CondEx !== 1'b1) begin
            errors++;
            $display("FAIL cmp_nowrite: RegWrite=%b CondEx=%b expected 0 1", bus.RegWrite, bus.CondEx);
        end
        tick();
        clear_inputs();
        bus.Cond = COND_EQ; bus.RegW = 1'b1;
        #1;
        checks++;
        if (bus.Flags !== 4'b0100 || bus.CondEx !== 1'b1 || bus.RegWrite !== 1'b1) begin
            errors++;
            $display("FAIL cmp_then_eq: Flags=%b CondEx=%b RegWrite=%b expected 0100 1 1",
                     bus.Flags, bus.CondEx, bus.RegWrite);
        end
        tick();
    endtask

    task automatic test_partial_update();
        reset = 1'b1;
        clear_inputs();
        #1;
        tick();
        reset = 1'b0;
        bus.FlagW = 2'b10; bus.ALUFlags = 4'b1111; bus.Cond = COND_AL;
        #1;
        tick();
        checks++;
        if (bus.Flags !== 4'b1100) begin
            errors++;
            $display("FAIL partial_nz: got %b expected 1100", bus.Flags);
        end
        bus.FlagW = 2'b01; bus.ALUFlags = 4'b0001;
        #1;
        tick();
        checks++;
        if (bus.Flags !== 4'b1101) begin
            errors++;
            $display("FAIL partial_cv: got %b expected 1101", bus.Flags);
        end
    endtask

    task automatic test_failed_cond();
        load_flags(4'b0100);
        bus.Cond = COND_NE; bus.FlagW = 2'b11; bus.ALUFlags = 4'b1011;
        bus.PCS = 1'b1; bus.MemW = 1'b1; bus.RegW = 1'b1;
        #1;
        checks++;
        if (bus.PCSrc !== 1'b0 || bus.MemWrite !== 1'b0 || bus.RegWrite !== 1'b0 || bus.CondEx !== 1'b0) begin
            errors++;
            $display("FAIL failed_cond_strobes: PCSrc=%b MemWrite=%b RegWrite=%b CondEx=%b expected 0",
                     bus.PCSrc, bus.MemWrite, bus.RegWrite, bus.CondEx);
        end
        tick();
        checks++;
        if (bus.Flags !== 4'b0100) begin
            errors++;
            $display("FAIL failed_cond_flags: got %b expected 0100", bus.Flags);
        end
    endtask

    task automatic test_signed();
        logic [3:0] conds1 [4];
        logic       exp1   [4];
        conds1 = '{COND_GE, COND_LT, COND_GT, COND_LE};
        exp1   = '{1'b0, 1'b1, 1'b0, 1'b1};
        load_flags(4'b1000);
        for (int i = 0; i < 4; i++) begin
            bus.Cond = conds1[i];
            #1;
            checks++;
            if (bus.CondEx !== exp1[i]) begin
                errors++;
                $display("FAIL signed_n1v0 cond=%b: got %b expected %b", conds1[i], bus.CondEx, exp1[i]);
            end
        end
        load_flags(4'b1001);
        bus.Cond = COND_GE;
        #1;
        checks++;
        if (bus.CondEx !== 1'b1) begin
            errors++;
            $display("FAIL signed_n1v1_ge: got %b expected 1", bus.CondEx);
        end
        bus.Cond = COND_GT;
        #1;
        checks++;
        if (bus.CondEx !== 1'b1) begin
            errors++;
            $display("FAIL signed_n1v1_gt: got %b expected 1", bus.CondEx);
        end
    endtask

    task automatic test_sweep();
        logic exp_ex;
        for (int f = 0; f < 16; f++) begin
            load_flags(4'(f));
            checks++;
            if (bus.Flags !== 4'(f)) begin
                errors++;
                $display("FAIL sweep_load: got %b expected %b", bus.Flags, 4'(f));
            end
            for (int c = 0; c < 16; c++) begin
                bus.Cond = 4'(c);
                bus.PCS = 1'($urandom_range(0, 1));
                bus.RegW = 1'($urandom_range(0, 1));
                bus.MemW = 1'($urandom_range(0, 1));
                bus.NoWrite = 1'($urandom_range(0, 1));
                #1;
                exp_ex = ref_cond(4'(c), 4'(f));
                checks++;
                if (bus.CondEx !== exp_ex || bus.PCSrc !== (bus.PCS && exp_ex) ||
                    bus.MemWrite !== (bus.MemW && exp_ex) ||
                    bus.RegWrite !== (bus.RegW && exp_ex && !bus.NoWrite)) begin
                    errors++;
                    $display("FAIL sweep cond=%b flags=%b: CondEx=%b PCSrc=%b MemWrite=%b RegWrite=%b expected CondEx=%b",
                             4'(c), 4'(f), bus.CondEx, bus.PCSrc, bus.MemWrite, bus.RegWrite, exp_ex);
                end
            end
        end
    endtask

    task automatic test_random_stream();
        logic exp_ex;
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 15) == 0);
            bus.Cond = 4'($urandom_range(0, 15));
            bus.ALUFlags = 4'($urandom_range(0, 15));
            bus.FlagW = 2'($urandom_range(0, 3));
            bus.PCS = 1'($urandom_range(0, 1));
            bus.RegW = 1'($urandom_range(0, 1));
            bus.MemW = 1'($urandom_range(0, 1));
            bus.NoWrite = 1'($urandom_range(0, 1));
            #1;
            exp_ex = !reset && ref_cond(bus.Cond, model_flags);
            checks++;
            if (bus.Flags !== model_flags || bus.CondEx !== exp_ex ||
                bus.PCSrc !== (bus.PCS && exp_ex) || bus.MemWrite !== (bus.MemW && exp_ex) ||
                bus.RegWrite !== (bus.RegW && exp_ex && !bus.NoWrite)) begin
                errors++;
                $display("FAIL random[%0d] rst=%b cond=%b: Flags=%b CondEx=%b PCSrc=%b MemWrite=%b RegWrite=%b expected Flags=%b CondEx=%b",
                         i, reset, bus.Cond, bus.Flags, bus.CondEx, bus.PCSrc, bus.MemWrite,
                         bus.RegWrite, model_flags, exp_ex);
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_flags = 4'b0000;
        reset = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_cmp_eq();
        test_partial_update();
        test_failed_cond();
        test_signed();
        test_sweep();
        test_random_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
